div_unit: RTL and testbench

Parametrised multi-cycle integer divider for the MIPS datapath's multiply/divide unit, serving both `div` (signed) and `divu` (unsigned). It computes one quotient bit per clock by shift-and-subtract on operand magnitudes, then applies a sign fix-up cycle. It has an explicit start/busy/done handshake, an abort input and a divide-by-zero flag. Results feed the HI/LO registers: `q` goes to LO and `r` goes to HI.

---
 rtl/div_unit_if.sv | 27 ++
 rtl/div_unit.sv | 160 ++++++++++++++++
 tb/tb_div_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Handshake and operand/result bundle for the multi-cycle divider.
interface div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             abort;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             div_zero;

    // Requester side
    modport master (
        output start, abort, is_signed, dividend, divisor,
        input  busy, done, q, r, div_zero
    );

    // Divider side
    modport slave (
        input  start, abort, is_signed, dividend, divisor,
        output busy, done, q, r, div_zero
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned integer divider: one quotient bit per clock by
// restoring shift-and-subtract on magnitudes, followed by a sign fix-up cycle.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    div_unit_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder, always < |divisor|
    logic [WIDTH-1:0] quo_q, quo_d;       // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] dvs_q, dvs_d;       // |divisor|
    logic [WIDTH-1:0] raw_q, raw_d;       // raw dividend for the divide-by-zero result
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   shift_rem;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            raw_q   <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            raw_q   <= raw_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    // Next-state, iteration datapath and result fix-up
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        raw_d   = raw_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        zero_d  = zero_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;

        dvd_mag   = (bus.is_signed && bus.dividend[WIDTH-1]) ? (~bus.dividend + WIDTH'(1))
                                                             : bus.dividend;
        dvs_mag   = (bus.is_signed && bus.divisor[WIDTH-1])  ? (~bus.divisor + WIDTH'(1))
                                                             : bus.divisor;
        // WIDTH+1-bit trial: bit WIDTH is the sign of the subtraction
        shift_rem = {rem_q, quo_q[WIDTH-1]};
        trial     = shift_rem - {1'b0, dvs_q};

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    rem_d   = '0;
                    quo_d   = dvd_mag;
                    dvs_d   = dvs_mag;
                    raw_d   = bus.dividend;
                    cnt_d   = CW'(WIDTH);
                    sgn_d   = bus.is_signed;
                    negq_d  = bus.is_signed && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                    negr_d  = bus.is_signed && bus.dividend[WIDTH-1];
                    zero_d  = (bus.divisor == '0);
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (bus.abort) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (!trial[WIDTH]) begin
                        rem_d = trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shift_rem[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (!bus.abort) begin
                    done_d = 1'b1;
                    if (zero_q) begin
                        q_d  = '1;
                        r_d  = raw_q;
                        dz_d = 1'b1;
                    end else begin
                        q_d  = (sgn_q && negq_q) ? (~quo_q + WIDTH'(1)) : quo_q;
                        r_d  = (sgn_q && negr_q) ? (~rem_q + WIDTH'(1)) : rem_q;
                        dz_d = 1'b0;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.q        = q_q;
    assign bus.r        = r_q;
    assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit at WIDTH = 32: directed table, random
// vectors against an arithmetic reference, and multi-cycle corner sequences.
module tb_div_unit;
    localparam int unsigned W = 32;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    div_unit_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Reference: plain language-level arithmetic with the divider's special cases
    task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        dz = (b == 0);
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = '0;
        end else begin
            q = W'($signed(a) / $signed(b));
            r = W'($signed(a) % $signed(b));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete division from the accepting edge to done, with latency and busy checks
    task automatic do_div(input string name, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eq,
                          input logic [W-1:0] er, input logic edz);
        int n;
        int busy_bad;
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.dividend  = a;
        bus.divisor   = b;
        tick();
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        bus.is_signed = 1'($urandom_range(0, 1));
        n = 0;
        busy_bad = 0;
        while (!bus.done && n < 100) begin
            if (!bus.busy) busy_bad++;
            tick();
            n++;
        end
        check({name, " latency"}, W'(n), W'(33));
        check({name, " busy"}, W'(busy_bad), W'(0));
        check({name, " q"}, bus.q, eq);
        check({name, " r"}, bus.r, er);
        check({name, " div_zero"}, W'(bus.div_zero), W'(edz));
        check({name, " busy after"}, W'(bus.busy), W'(0));
    endtask

    initial begin
        logic [W-1:0] a, b, eq, er;
        logic         s, edz;
        int           n;
        int           dones;

        vectors     = 0;
        miscompares = 0;
        tbl[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
        tbl[1]  = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
        tbl[2]  = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0};
        tbl[3]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0};
        tbl[4]  = '{1'b1, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1};
        tbl[5]  = '{1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1};
        tbl[6]  = '{1'b0, 32'd9,         32'd3,         32'd3,         32'd0,         1'b0};
        tbl[7]  = '{1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0};
        tbl[8]  = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
        tbl[9]  = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 1'b0};
        tbl[10] = '{1'b0, 32'd3,         32'd10,        32'd0,         32'd3,         1'b0};

        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        tick();
        tick();
        check("reset busy", W'(bus.busy), W'(0));
        check("reset done", W'(bus.done), W'(0));
        check("reset q", bus.q, '0);
        check("reset r", bus.r, '0);
        check("reset div_zero", W'(bus.div_zero), W'(0));
        reset_n = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 11; i++) begin
            do_div($sformatf("tbl%0d", i), tbl[i].s, tbl[i].a, tbl[i].b,
                   tbl[i].q, tbl[i].r, tbl[i].dz);
        end

        // Random vectors against the reference
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = '0;
                1: b = W'($urandom_range(1, 15));
                2: b = ~W'($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            if (i == 7) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            model(s, a, b, eq, er, edz);
            do_div($sformatf("rnd%0d", i), s, a, b, eq, er, edz);
        end

        // Abort at edge 10: no done, previous result held
        do_div("pre_abort", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort busy", W'(bus.busy), W'(0));
        check("abort done", W'(bus.done), W'(0));
        check("abort q held", bus.q, 32'd3);
        check("abort r held", bus.r, 32'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) dones++;
        end
        check("abort no done", W'(dones), W'(0));

        // Abort has priority over start in IDLE
        bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        check("idle abort busy", W'(bus.busy), W'(0));

        // Start while busy is ignored
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
        tick();
        bus.start = 1'b0;
        n = 5;
        while (!bus.done && n < 100) begin
            tick();
            n++;
        end
        check("ign latency", W'(n), W'(33));
        check("ign q", bus.q, 32'd14);
        check("ign r", bus.r, 32'd2);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) dones++;
        end
        check("ign no second done", W'(dones), W'(0));

        // Back-to-back: start held through the done cycle
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
        tick();
        bus.dividend = 32'd9; bus.divisor = 32'd3;
        n = 0;
        while (!bus.done && n < 100) begin
            tick();
            n++;
        end
        check("b2b first latency", W'(n), W'(33));
        check("b2b first q", bus.q, 32'd14);
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) begin
                bus.start = 1'b0;
                check("b2b q held", bus.q, 32'd14);
                check("b2b busy", W'(bus.busy), W'(1));
            end
        end while (!bus.done && n < 100);
        check("b2b second gap", W'(n), W'(34));
        check("b2b second q", bus.q, 32'd3);
        check("b2b second r", bus.r, 32'd0);

        // Asynchronous reset mid-CALC
        bus.start = 1'b1; bus.is_signed = 1'b1; bus.dividend = 32'hFFFF_FFF9; bus.divisor = 32'd2;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst busy", W'(bus.busy), W'(0));
        check("rst done", W'(bus.done), W'(0));
        check("rst q", bus.q, '0);
        check("rst r", bus.r, '0);
        check("rst div_zero", W'(bus.div_zero), W'(0));
        tick();
        reset_n = 1'b1;
        tick();
        model(1'b1, 32'hFFFF_FF9C, 32'd7, eq, er, edz);
        do_div("post_rst", 1'b1, 32'hFFFF_FF9C, 32'd7, eq, er, edz);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
